sfu_vec: RTL and testbench

- Multi-channel, parametrised successor to the single-lane special function unit.
- Accumulates a programmable number of partial-sum vectors per output: `acc_len` beats across `col` channels in parallel.
- Uses a widened internal accumulator, then applies signed saturation and optional ReLU.
- Delivers one result vector over a valid/ready handshake. Sits between psum memory readout and output SRAM write-back.

---
 rtl/sfu_vec.sv | 167 ++++++++++++++++
 tb/tb_sfu_vec.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sfu_vec.sv
`default_nettype none
// ============================================================================
// Module   : sfu_vec
// Purpose  : Multi-channel special function unit. Accumulates acc_len psum
//            vectors per output group in widened per-lane accumulators. It then
//            applies signed saturation to PSUM_BW bits and an optional ReLU.
//            The finished vector is held on a valid/ready output handshake.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            acc_len, relu_en - group length / ReLU enable, sampled on the
//                               first beat of a group (acc_len 0 means 1)
//            in_valid/in_ready, psum_in - input vector handshake
//            out_valid/out_ready, sfp_out - result vector handshake
//            ovf_flag         - per-lane saturation indicator for sfp_out
//            busy             - high while accumulating or holding a result
// Revision : 1.0 - initial release
// ============================================================================
module sfu_vec #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int CNT_BW  = 4,
  parameter int ACC_BW  = PSUM_BW + CNT_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CNT_BW-1:0]      acc_len,
  input  logic                   relu_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COL*PSUM_BW-1:0] psum_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COL*PSUM_BW-1:0] sfp_out,
  output logic [COL-1:0]         ovf_flag,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Saturation bounds expressed at accumulator width; the minimum is the
  // bitwise complement of the maximum (0..01..1 -> 1..10..0).
  localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << (PSUM_BW - 1)) - 1);
  localparam logic signed [ACC_BW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                    state_q, state_d;
  logic [CNT_BW-1:0]         cnt_q;
  logic [CNT_BW-1:0]         len_q;
  logic                      relu_q;
  logic signed [ACC_BW-1:0]  acc_q [COL];
  logic [COL*PSUM_BW-1:0]    sfp_q;
  logic [COL-1:0]            ovf_q;

  logic                      w_beat;
  logic                      w_final;
  logic                      w_relu;
  logic [CNT_BW-1:0]         w_eff_len;
  logic [CNT_BW-1:0]         w_cnt_inc;
  logic signed [ACC_BW-1:0]  w_sum [COL];
  logic [COL*PSUM_BW-1:0]    w_res;
  logic [COL-1:0]            w_ovf;

  assign in_ready  = (state_q != S_HOLD);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign sfp_out   = sfp_q;
  assign ovf_flag  = ovf_q;

  assign w_beat    = in_valid & in_ready;
  assign w_eff_len = (acc_len == '0) ? CNT_BW'(1) : acc_len;
  assign w_cnt_inc = cnt_q + CNT_BW'(1);
  // On the first beat the live inputs apply; afterwards the latched copies.
  assign w_relu    = (state_q == S_IDLE) ? relu_en : relu_q;

  // Per-lane datapath: running sum, saturation and ReLU.
  for (genvar i = 0; i < COL; i++) begin : g_lane
    logic signed [ACC_BW-1:0]  w_ext;
    logic signed [ACC_BW-1:0]  w_base;
    logic signed [ACC_BW-1:0]  w_lane_sum;
    logic                      w_hi;
    logic                      w_lo;
    logic [PSUM_BW-1:0]        w_sat;

    assign w_ext = {{(ACC_BW - PSUM_BW){psum_in[PSUM_BW*(i+1)-1]}},
                    psum_in[PSUM_BW*i +: PSUM_BW]};
    // The first beat of a group starts from zero regardless of acc_q.
    assign w_base     = (state_q == S_ACC) ? acc_q[i] : '0;
    assign w_lane_sum = w_base + w_ext;
    assign w_hi       = (w_lane_sum > SAT_MAX);
    assign w_lo       = (w_lane_sum < SAT_MIN);
    assign w_sat      = w_hi ? SAT_MAX[PSUM_BW-1:0] :
                        w_lo ? SAT_MIN[PSUM_BW-1:0] :
                               w_lane_sum[PSUM_BW-1:0];

    assign w_sum[i]                      = w_lane_sum;
    assign w_res[PSUM_BW*i +: PSUM_BW]   = (w_relu && w_sat[PSUM_BW-1]) ? '0 : w_sat;
    assign w_ovf[i]                      = w_hi | w_lo;
  end : g_lane

  // Next-state logic and final-beat detection.
  always_comb begin
    state_d = state_q;
    w_final = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_beat) begin
          w_final = (w_eff_len == CNT_BW'(1));
          state_d = w_final ? S_HOLD : S_ACC;
        end
      end
      S_ACC: begin
        if (w_beat && (w_cnt_inc == len_q)) begin
          w_final = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= CNT_BW'(1);
      relu_q  <= 1'b0;
      sfp_q   <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < COL; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (w_beat) begin
        for (int i = 0; i < COL; i++) begin
          acc_q[i] <= w_sum[i];
        end
        if (state_q == S_IDLE) begin
          cnt_q  <= CNT_BW'(1);
          len_q  <= w_eff_len;
          relu_q <= relu_en;
        end else begin
          cnt_q <= w_cnt_inc;
        end
      end
      if (w_final) begin
        sfp_q <= w_res;
        ovf_q <= w_ovf;
      end
      if ((state_q == S_HOLD) && out_ready) begin
        cnt_q <= '0;
        for (int i = 0; i < COL; i++) begin
          acc_q[i] <= '0;
        end
      end
    end
  end

endmodule : sfu_vec
`default_nettype wire

// File: tb/tb_sfu_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfu_vec
// Purpose  : Directed self-checking bench for sfu_vec (default parameters:
//            8 lanes of 16 bits, 4-bit length). Expected values are constants
//            worked out by hand from the lane arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfu_vec;

  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int VW  = COL * PW;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    acc_len;
  logic          relu_en;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] psum_in;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] sfp_out;
  logic [COL-1:0] ovf_flag;
  logic          busy;

  int total = 0;
  int bad   = 0;

  sfu_vec dut (
    .clk       (clk),
    .reset     (reset),
    .acc_len   (acc_len),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .psum_in   (psum_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sfp_out   (sfp_out),
    .ovf_flag  (ovf_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Build a vector with lanes 0..2 set and the rest zero.
  function automatic logic [VW-1:0] vec3(input logic [15:0] l0, input logic [15:0] l1,
                                         input logic [15:0] l2);
    logic [VW-1:0] v;
    v = '0;
    v[15:0]  = l0;
    v[31:16] = l1;
    v[47:32] = l2;
    return v;
  endfunction

  task automatic beat(input logic [VW-1:0] v);
    in_valid = 1'b1;
    psum_in  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_after_hs"}, VW'(out_valid), VW'(1'b0));
  endtask

  logic [VW-1:0] held;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    psum_in   = vec3(16'd5, 16'd5, 16'd5);
    acc_len   = 4'd1;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst_sfp",   sfp_out, '0);
    chk("rst_ovf",   VW'(ovf_flag), '0);
    chk("rst_ov",    VW'(out_valid), '0);
    chk("rst_ir",    VW'(in_ready), VW'(1'b1));
    chk("rst_busy",  VW'(busy), '0);

    // Basic group with ReLU; acc_len is changed mid-group and must be ignored.
    acc_len = 4'd3; relu_en = 1'b1;
    beat(vec3(16'd10, -16'sd5, 16'd0));
    acc_len = 4'd7; relu_en = 1'b0;
    chk("b1_busy", VW'(busy), VW'(1'b1));
    beat(vec3(-16'sd4, -16'sd5, 16'd0));
    chk("b1_ov_early", VW'(out_valid), '0);
    beat(vec3(16'd7, -16'sd5, 16'd0));
    chk("b1_ov", VW'(out_valid), VW'(1'b1));
    chk("b1_sfp", sfp_out, vec3(16'd13, 16'd0, 16'd0));
    chk("b1_ovf", VW'(ovf_flag), '0);
    handshake("b1");

    // Same data without ReLU.
    acc_len = 4'd3; relu_en = 1'b0;
    beat(vec3(16'd10, -16'sd5, 16'd0));
    beat(vec3(-16'sd4, -16'sd5, 16'd0));
    beat(vec3(16'd7, -16'sd5, 16'd0));
    chk("b2_sfp", sfp_out, vec3(16'd13, 16'hFFF1, 16'd0));
    handshake("b2");

    // Positive saturation on lane 0.
    acc_len = 4'd4; relu_en = 1'b0;
    for (int k = 0; k < 4; k++) beat(vec3(16'h7000, 16'd1, 16'd0));
    chk("sp_sfp", sfp_out, vec3(16'h7FFF, 16'd4, 16'd0));
    chk("sp_ovf", VW'(ovf_flag), VW'(8'h01));
    handshake("sp");

    // Negative saturation on lane 2.
    acc_len = 4'd2; relu_en = 1'b0;
    for (int k = 0; k < 2; k++) beat(vec3(16'd0, 16'd0, 16'h8000));
    chk("sn_sfp", sfp_out, vec3(16'd0, 16'd0, 16'h8000));
    chk("sn_ovf", VW'(ovf_flag), VW'(8'h04));
    handshake("sn");
    chk("sn_retain", sfp_out, vec3(16'd0, 16'd0, 16'h8000));

    // Bubbles between beats, then output backpressure with in_valid asserted.
    acc_len = 4'd2; relu_en = 1'b0;
    beat(vec3(16'd100, 16'd0, 16'd0));
    psum_in = vec3(16'd1234, 16'd1234, 16'd1234);
    tick(); tick(); tick();
    chk("bub_ov", VW'(out_valid), '0);
    beat(vec3(16'd23, 16'd0, 16'd0));
    held = vec3(16'd123, 16'd0, 16'd0);
    in_valid = 1'b1;
    psum_in  = vec3(16'd999, 16'd999, 16'd999);
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov",  VW'(out_valid), VW'(1'b1));
      chk("bp_ir",  VW'(in_ready), '0);
      chk("bp_sfp", sfp_out, held);
      tick();
    end
    // in_valid stays high through the handshake cycle; nothing may be taken.
    handshake("bp");
    in_valid = 1'b0;
    chk("bp_idle", VW'(busy), '0);
    chk("bp_retain", sfp_out, held);

    // acc_len = 0 behaves as a single-beat group.
    acc_len = 4'd0; relu_en = 1'b1;
    beat(vec3(-16'sd3, 16'd9, 16'd0));
    chk("l0_ov",  VW'(out_valid), VW'(1'b1));
    chk("l0_sfp", sfp_out, vec3(16'd0, 16'd9, 16'd0));
    handshake("l0");

    acc_len = 4'd1; relu_en = 1'b0;
    beat(vec3(-16'sd3, 16'd9, 16'd0));
    chk("l1_ov",  VW'(out_valid), VW'(1'b1));
    chk("l1_sfp", sfp_out, vec3(16'hFFFD, 16'd9, 16'd0));
    handshake("l1");

    // Longest group: 15 x 0x7FFF = 491505, fits in 20 bits, clamps to 0x7FFF.
    acc_len = 4'd15; relu_en = 1'b0;
    for (int k = 0; k < 14; k++) beat(vec3(16'h7FFF, 16'd0, 16'd0));
    chk("l15_ov_early", VW'(out_valid), '0);
    beat(vec3(16'h7FFF, 16'd0, 16'd0));
    chk("l15_sfp", sfp_out, vec3(16'h7FFF, 16'd0, 16'd0));
    chk("l15_ovf", VW'(ovf_flag), VW'(8'h01));
    handshake("l15");

    // Reset part-way through a group discards the partial sum.
    acc_len = 4'd3; relu_en = 1'b0;
    beat(vec3(16'd50, 16'd0, 16'd0));
    beat(vec3(16'd50, 16'd0, 16'd0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_busy", VW'(busy), '0);
    chk("mr_sfp",  sfp_out, '0);
    for (int k = 0; k < 3; k++) beat(vec3(16'd1, 16'd0, 16'd0));
    chk("mr_ov",  VW'(out_valid), VW'(1'b1));
    chk("mr_sfp2", sfp_out, vec3(16'd3, 16'd0, 16'd0));
    handshake("mr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sfu_vec
`default_nettype wire
